// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a length-prefixed little-endian byte
// stream into 32-bit words, writes them out, and verifies a trailing XOR checksum.
module imem_loader #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic            byte_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            core_hold,
    output logic            done,
    output logic            error
);

    localparam int unsigned IDXW    = $clog2(DEPTH) + 1;
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t            state_q;
    logic [15:0]       n_q;
    logic [IDXW-1:0]   idx_q;
    logic [1:0]        bcnt_q;
    logic [7:0]        csum_q;
    logic [XLEN-1:0]   word_q;
    logic              mem_we_q;
    logic [XLEN-1:0]   mem_addr_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic              core_hold_q;
    logic              done_q;
    logic              error_q;

    logic              accept;
    logic [15:0]       n_d;
    logic [XLEN-1:0]   word_d;
    logic              last_word;

    assign byte_ready = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                        (state_q == S_DATA) || (state_q == S_CHECK);
    assign accept     = byte_valid && byte_ready;
    assign n_d        = {byte_data, n_q[7:0]};
    assign last_word  = ({{(16-IDXW){1'b0}}, idx_q} == (n_q - 16'd1));

    always_comb begin
        word_d = word_q;
        case (bcnt_q)
            2'd0:    word_d[7:0]   = byte_data;
            2'd1:    word_d[15:8]  = byte_data;
            2'd2:    word_d[23:16] = byte_data;
            default: word_d[31:24] = byte_data;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            idx_q       <= '0;
            bcnt_q      <= '0;
            csum_q      <= '0;
            word_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_hold_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q     <= S_LEN0;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        idx_q       <= '0;
                        bcnt_q      <= '0;
                        csum_q      <= '0;
                        core_hold_q <= 1'b1;
                    end
                end
                S_LEN0: begin
                    if (accept) begin
                        n_q     <= {8'h00, byte_data};
                        state_q <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (accept) begin
                        n_q <= n_d;
                        if (n_d == 16'd0) begin
                            state_q <= S_CHECK;
                        end else if (n_d > DEPTH16) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        word_q <= word_d;
                        csum_q <= csum_q ^ byte_data;
                        bcnt_q <= bcnt_q + 2'd1;
                        // Address and data are captured here so they are stable throughout WRITE.
                        if (bcnt_q == 2'd3) begin
                            state_q     <= S_WRITE;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {{(XLEN-IDXW-2){1'b0}}, idx_q, 2'b00};
                            mem_wdata_q <= word_d;
                        end
                    end
                end
                S_WRITE: begin
                    idx_q   <= idx_q + 1'b1;
                    state_q <= last_word ? S_CHECK : S_DATA;
                end
                S_CHECK: begin
                    if (accept) begin
                        if (byte_data == csum_q) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            core_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_hold = core_hold_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, length limits, empty
// load, stalled stream with spurious start pulses, and reset mid-load.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned rdy_in_write = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    imem_loader #(.XLEN(32), .DEPTH(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            if (byte_ready) rdy_in_write++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("byte_ack", {31'b0, byte_ready}, 32'd1);
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] cs, input bit gaps);
        logic [7:0] s [11];
        s = '{8'h02, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h00,
              8'hB3, 8'h02, 8'h32, 8'h40, 8'h00};
        s[10] = cs;
        for (int i = 0; i < 11; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if (i % 3 == 1) pulse_start();
            end
            send_byte(s[i]);
        end
    endtask

    task automatic check_two_writes(input string tag);
        check({tag, "_nwr"}, wa.size(), 32'd2);
        if (wa.size() == 2) begin
            check({tag, "_a0"}, wa[0], 32'h0000_0000);
            check({tag, "_d0"}, wd[0], 32'h0020_81B3);
            check({tag, "_a1"}, wa[1], 32'h0000_0004);
            check({tag, "_d1"}, wd[1], 32'h4032_02B3);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = '0;
        #1;
        check("rst_flags", {27'b0, byte_ready, mem_we, core_hold, done, error}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Good load; payload XOR = D1
        wa.delete(); wd.delete();
        pulse_start();
        check("t2_hold_run", {31'b0, core_hold}, 32'd1);
        send_stream(8'hD1, 1'b0);
        check_two_writes("t2");
        check("t2_done", {31'b0, done}, 32'd1);
        check("t2_err", {31'b0, error}, 32'd0);
        check("t2_hold", {31'b0, core_hold}, 32'd0);

        // Bad checksum
        wa.delete(); wd.delete();
        pulse_start();
        send_stream(8'h00, 1'b0);
        check_two_writes("t3");
        check("t3_err", {31'b0, error}, 32'd1);
        check("t3_hold", {31'b0, core_hold}, 32'd1);
        check("t3_done", {31'b0, done}, 32'd0);
        pulse_start();
        check("t3_errclr", {31'b0, error}, 32'd0);

        // Oversize header straight after restart
        wa.delete(); wd.delete();
        send_byte(8'h41);
        send_byte(8'h00);
        check("t4_err", {31'b0, error}, 32'd1);
        check("t4_rdy", {31'b0, byte_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check("t4_nwr", wa.size(), 32'd0);

        // Empty load
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("t5_done", {31'b0, done}, 32'd1);
        check("t5_err", {31'b0, error}, 32'd0);
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h5A);
        check("t5_err2", {31'b0, error}, 32'd1);
        check("t5_done2", {31'b0, done}, 32'd0);
        check("t5_nwr", wa.size(), 32'd0);

        // Stalled stream with start pulses during the load
        wa.delete(); wd.delete();
        rdy_in_write = 0;
        pulse_start();
        send_stream(8'hD1, 1'b1);
        check_two_writes("t6");
        check("t6_done", {31'b0, done}, 32'd1);
        check("t6_rdy_wr", rdy_in_write, 32'd0);

        // Reset during payload, one word already written
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'hB3); send_byte(8'h81); send_byte(8'h20); send_byte(8'h00);
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("t1_flags", {27'b0, byte_ready, mem_we, core_hold, done, error}, 32'd0);
        check("t1_addr", mem_addr, 32'd0);
        check("t1_wdata", mem_wdata, 32'd0);
        check("t1_nwr_pre", wa.size(), 32'd1);
        @(negedge clk) reset = 1'b0;
        byte_valid = 1'b1; byte_data = 8'hB3;
        repeat (10) @(negedge clk);
        byte_valid = 1'b0;
        check("t1_nwr", wa.size(), 32'd1);
        check("t1_idle_rdy", {31'b0, byte_ready}, 32'd0);
        check("t1_idle_hold", {31'b0, core_hold}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
